// File: rtl/seq_div_32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_32_pkg
// Purpose  : Shared definitions for the sequential restoring divider: datapath
//            width, index limit and the 3-bit FSM state encodings.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package seq_div_32_pkg;

    localparam int c_data_width       = 32;
    localparam int c_data_index_limit = c_data_width - 1;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_init = 3'd1;
    localparam logic [2:0] c_st_iter = 3'd2;
    localparam logic [2:0] c_st_fix  = 3'd3;
    localparam logic [2:0] c_st_fin  = 3'd4;

    typedef enum logic [2:0] {
        st_idle = c_st_idle,
        st_init = c_st_init,
        st_iter = c_st_iter,
        st_fix  = c_st_fix,
        st_fin  = c_st_fin
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_div_32_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_32_if
// Purpose  : Request/response bundle between the control unit (master) and
//            the sequential divider (slave).
// Signals  : start, signed_op, a, b      master -> divider
//            q, r, busy, done, div_by_zero divider -> master
// Revision : 1.0  initial release
// ============================================================================
interface seq_div_32_if
    import seq_div_32_pkg::*;
#(
    parameter int WIDTH = c_data_width
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, signed_op, a, b,
        input  q, r, busy, done, div_by_zero
    );

    modport slave (
        input  start, signed_op, a, b,
        output q, r, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_div_32_div_step.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_32_div_step
// Purpose  : One combinational restoring-division iteration: shift the next
//            dividend bit into the partial remainder, trial-subtract the
//            divisor, keep the difference when it does not go negative.
// Ports    : i_p        WIDTH+1  current partial remainder
//            i_bit      1        next dividend bit (MSB first)
//            i_divisor  WIDTH    divisor magnitude
//            o_p        WIDTH+1  updated partial remainder
//            o_q_bit    1        quotient bit produced by this step
// Revision : 1.0  initial release
// ============================================================================
module seq_div_32_div_step
    import seq_div_32_pkg::*;
#(
    parameter int WIDTH = c_data_width
) (
    input  wire logic [WIDTH:0]   i_p,
    input  wire logic             i_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH:0]   o_p,
    output logic                  o_q_bit
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {i_p[WIDTH-1:0], i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};

    // Bit WIDTH of the difference is the borrow. A set top bit in i_p would
    // mean the shifted value already exceeds any divisor, so it forces success.
    assign o_q_bit = i_p[WIDTH] | ~w_diff[WIDTH];
    assign o_p     = o_q_bit ? w_diff : w_shifted;

endmodule
`default_nettype wire

// File: rtl/seq_div_32.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_32
// Purpose  : Multi-cycle restoring divider (signed or unsigned). One
//            conditional subtract per cycle; quotient truncates toward zero
//            and the remainder takes the dividend's sign.
// Ports    : clk   system clock, rising edge
//            rst   synchronous active-high reset, aborts any operation
//            bus   seq_div_32_if.slave: start/signed_op/a/b in,
//                  q/r/busy/done/div_by_zero out
// Revision : 1.0  initial release
// ============================================================================
module seq_div_32
    import seq_div_32_pkg::*;
#(
    parameter int WIDTH = c_data_width
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_div_32_if.slave bus
);
    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [WIDTH:0]     r_p;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_dbz;

    logic               w_busy;
    logic               w_done;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_p_next;
    logic               w_q_bit;

    // Magnitudes; negating the most negative value wraps to itself, which
    // is still the correct unsigned magnitude.
    assign w_a_neg  = r_signed & r_a[WIDTH-1];
    assign w_b_neg  = r_signed & r_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -r_a : r_a;
    assign w_b_mag  = w_b_neg ? -r_b : r_b;
    assign w_b_zero = (r_b == '0);

    seq_div_32_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_p       (r_p),
        .i_bit     (r_d[WIDTH-1]),
        .i_divisor (r_div),
        .o_p       (w_p_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= st_idle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            st_idle: if (bus.start) w_state_next = st_init;
            st_init: begin
                w_busy       = 1'b1;
                w_state_next = w_b_zero ? st_fix : st_iter;
            end
            st_iter: begin
                w_busy = 1'b1;
                if (r_count == '0) w_state_next = st_fix;
            end
            st_fix: begin
                w_busy       = 1'b1;
                w_state_next = st_fin;
            end
            st_fin: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = st_idle;
            end
            default: w_state_next = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_p      <= '0;
            r_d      <= '0;
            r_div    <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_dbz    <= 1'b0;
        end else begin
            unique case (r_state)
                st_idle: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_signed <= bus.signed_op;
                    end
                end
                st_init: begin
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_p     <= '0;
                    r_d     <= w_a_mag;
                    r_div   <= w_b_mag;
                    r_count <= c_cnt_last;
                end
                st_iter: begin
                    // {P,D} shifts left together; D's LSB collects quotient bits.
                    r_p <= w_p_next;
                    r_d <= {r_d[WIDTH-2:0], w_q_bit};
                    if (r_count != '0) r_count <= r_count - c_cnt_w'(1);
                end
                st_fix: begin
                    if (w_b_zero) begin
                        r_q   <= '1;
                        r_r   <= r_a;
                        r_dbz <= 1'b1;
                    end else begin
                        r_q   <= r_q_neg ? -r_d : r_d;
                        r_r   <= r_r_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q           = r_q;
    assign bus.r           = r_r;
    assign bus.div_by_zero = r_dbz;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;

endmodule
`default_nettype wire
